// File: rtl/uf_label_scheduler.sv
// Sequencer that owns the union_find op port: initialises it per frame, issues
// one union per buffered equivalence pair, then streams a label->root remap table.
module uf_label_scheduler #(
  parameter int N          = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic [ADDR_WIDTH-1:0] max_label,
  input  logic                  eq_valid,
  output logic                  eq_ready,
  input  logic [ADDR_WIDTH-1:0] eq_a,
  input  logic [ADDR_WIDTH-1:0] eq_b,
  output logic                  uf_frame_start,
  output logic [1:0]            uf_op,
  output logic [ADDR_WIDTH-1:0] uf_node1,
  output logic [ADDR_WIDTH-1:0] uf_node2,
  input  logic [ADDR_WIDTH-1:0] uf_result,
  input  logic                  uf_done,
  input  logic                  uf_idle,
  output logic                  remap_valid,
  output logic [ADDR_WIDTH-1:0] remap_addr,
  output logic [ADDR_WIDTH-1:0] remap_data,
  output logic [ADDR_WIDTH-1:0] num_components,
  output logic                  resolve_done,
  output logic                  busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]            PTR_ONE    = (PTR_W + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0]     LABEL_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]     LAST_LABEL = ADDR_WIDTH'(N - 1);

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_UNION = 2'b01;
  localparam logic [1:0] OP_FIND  = 2'b10;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_INIT_REQ  = 4'd1;
  localparam logic [3:0] S_INIT_WAIT = 4'd2;
  localparam logic [3:0] S_RUN       = 4'd3;
  localparam logic [3:0] S_ISSUE_U   = 4'd4;
  localparam logic [3:0] S_WAIT_U    = 4'd5;
  localparam logic [3:0] S_FIND      = 4'd6;
  localparam logic [3:0] S_WAIT_F    = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;
  localparam logic [3:0] S_ABORT     = 4'd9;  // restart pending: drain the in-flight op, then re-init

  logic [3:0]            state;
  logic                  armed;
  logic                  end_pending;
  logic                  init_first;
  logic                  op_out;
  logic [ADDR_WIDTH-1:0] max_q;
  logic [ADDR_WIDTH-1:0] counter;
  logic [ADDR_WIDTH-1:0] count;

  logic [ADDR_WIDTH-1:0] fifo_a [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_b [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr;
  logic [PTR_W:0]        rd_ptr;

  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  accept_state;
  logic                  pair_keep;
  logic                  push;
  logic                  pop;
  logic                  abort;
  logic                  end_ok;
  logic [ADDR_WIDTH-1:0] count_next;
  logic [ADDR_WIDTH-1:0] max_clamped;

  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign accept_state = state inside {S_INIT_WAIT, S_RUN, S_ISSUE_U, S_WAIT_U};
  assign eq_ready     = armed && !fifo_full && accept_state;

  // Self-pairs and background pairs complete the handshake but carry no information.
  assign pair_keep    = (eq_a != eq_b) && (eq_a != '0) && (eq_b != '0);
  assign push         = eq_valid && eq_ready && pair_keep;
  assign pop          = (state == S_ISSUE_U);
  assign abort        = frame_start && (state != S_IDLE) && (state != S_DONE);
  assign end_ok       = frame_end && armed && (state inside {S_RUN, S_ISSUE_U, S_WAIT_U});

  assign count_next   = (uf_result == counter) ? count + LABEL_ONE : count;
  assign max_clamped  = (max_label > LAST_LABEL) ? LAST_LABEL : max_label;

  assign uf_frame_start = (state == S_INIT_REQ);
  assign busy           = !((state == S_IDLE) || ((state == S_RUN) && fifo_empty));

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    uf_op    = OP_NONE;
    uf_node1 = '0;
    uf_node2 = '0;
    case (state)
      S_ISSUE_U: begin
        uf_op    = OP_UNION;
        uf_node1 = fifo_a[rd_ptr[PTR_W-1:0]];
        uf_node2 = fifo_b[rd_ptr[PTR_W-1:0]];
      end
      S_FIND: begin
        if (uf_idle) begin
          uf_op    = OP_FIND;
          uf_node1 = counter;
        end
      end
      default: ;
    endcase
  end

  // NOTE: pair storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr[PTR_W-1:0]] <= eq_a;
      fifo_b[wr_ptr[PTR_W-1:0]] <= eq_b;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; later ones in the block take priority.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      armed          <= 1'b0;
      end_pending    <= 1'b0;
      init_first     <= 1'b0;
      op_out         <= 1'b0;
      max_q          <= '0;
      counter        <= '0;
      count          <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      remap_valid    <= 1'b0;
      remap_addr     <= '0;
      remap_data     <= '0;
      num_components <= '0;
      resolve_done   <= 1'b0;
    end else begin
      remap_valid  <= 1'b0;
      resolve_done <= 1'b0;

      if (uf_done) op_out <= 1'b0;
      if (uf_op != OP_NONE) op_out <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

      if (abort) begin
        state       <= S_ABORT;
        armed       <= 1'b0;
        end_pending <= 1'b0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
      end else begin
        if (end_ok) begin
          max_q       <= max_clamped;
          end_pending <= 1'b1;
        end

        case (state)
          S_IDLE:      if (frame_start) state <= S_INIT_REQ;
          S_INIT_REQ: begin
            init_first <= 1'b1;
            state      <= S_INIT_WAIT;
          end
          S_INIT_WAIT: begin
            if (init_first) begin
              init_first <= 1'b0;
            end else if (uf_idle) begin
              armed <= 1'b1;
              state <= S_RUN;
            end
          end
          S_RUN: begin
            if (!fifo_empty && uf_idle) begin
              state <= S_ISSUE_U;
            end else if (end_pending && fifo_empty) begin
              end_pending <= 1'b0;
              count       <= '0;
              if (max_q == '0) begin
                num_components <= '0;
                resolve_done   <= 1'b1;
                armed          <= 1'b0;
                state          <= S_DONE;
              end else begin
                counter <= LABEL_ONE;
                state   <= S_FIND;
              end
            end
          end
          S_ISSUE_U:   state <= S_WAIT_U;
          S_WAIT_U:    if (uf_done) state <= S_RUN;
          S_FIND:      if (uf_idle) state <= S_WAIT_F;
          S_WAIT_F: begin
            if (uf_done) begin
              remap_valid <= 1'b1;
              remap_addr  <= counter;
              remap_data  <= uf_result;
              count       <= count_next;
              if (counter == max_q) begin
                num_components <= count_next;
                resolve_done   <= 1'b1;
                armed          <= 1'b0;
                state          <= S_DONE;
              end else begin
                counter <= counter + LABEL_ONE;
                state   <= S_FIND;
              end
            end
          end
          S_DONE:      state <= frame_start ? S_INIT_REQ : S_IDLE;
          S_ABORT:     if (uf_idle && !op_out) state <= S_INIT_REQ;
          default:     state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uf_label_scheduler.sv
// Bench for uf_label_scheduler: a behavioural union_find answers the op port,
// directed pair tables are pushed per frame and the remap stream is compared.
module tb_uf_label_scheduler;

  localparam int N  = 16;
  localparam int AW = 8;
  localparam int FD = 4;

  typedef struct {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    bit            stored;
  } pair_vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } pair_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          frame_end = 1'b0;
  logic [AW-1:0] max_label = '0;
  logic          eq_valid = 1'b0;
  logic [AW-1:0] eq_a = '0;
  logic [AW-1:0] eq_b = '0;
  logic          eq_ready;
  logic          uf_frame_start;
  logic [1:0]    uf_op;
  logic [AW-1:0] uf_node1, uf_node2;
  logic [AW-1:0] uf_result;
  logic          uf_done = 1'b0;
  logic          uf_idle;
  logic          remap_valid;
  logic [AW-1:0] remap_addr, remap_data, num_components;
  logic          resolve_done;
  logic          busy;

  always #5 clk = ~clk;

  uf_label_scheduler #(.N(N), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .frame_end(frame_end),
    .max_label(max_label), .eq_valid(eq_valid), .eq_ready(eq_ready), .eq_a(eq_a), .eq_b(eq_b),
    .uf_frame_start(uf_frame_start), .uf_op(uf_op), .uf_node1(uf_node1), .uf_node2(uf_node2),
    .uf_result(uf_result), .uf_done(uf_done), .uf_idle(uf_idle),
    .remap_valid(remap_valid), .remap_addr(remap_addr), .remap_data(remap_data),
    .num_components(num_components), .resolve_done(resolve_done), .busy(busy)
  );

  // Behavioural union_find: N-cycle init after uf_frame_start, 2-3 cycle ops,
  // uf_done coincides with the return to idle; union links the larger root under the smaller.
  logic [AW-1:0] parent [0:N-1];
  logic [AW-1:0] res_q = '0;
  logic [AW-1:0] ra, rb;
  int            init_cnt = 0;
  int            op_cnt = 0;

  assign uf_idle   = (init_cnt == 0) && (op_cnt == 0);
  assign uf_result = res_q;

  function automatic logic [AW-1:0] root_of(input logic [AW-1:0] x);
    logic [AW-1:0] r;
    r = x;
    for (int k = 0; k < N && parent[r] != r; k++) r = parent[r];
    return r;
  endfunction

  always @(posedge clk) begin
    uf_done <= 1'b0;
    if (!reset_n) begin
      init_cnt <= 0;
      op_cnt   <= 0;
      res_q    <= '0;
    end else if (uf_frame_start) begin
      for (int i = 0; i < N; i++) parent[i] = AW'(i);
      init_cnt <= N;
      op_cnt   <= 0;
    end else if (init_cnt != 0) begin
      init_cnt <= init_cnt - 1;
    end else if (op_cnt != 0) begin
      op_cnt <= op_cnt - 1;
      if (op_cnt == 1) uf_done <= 1'b1;
    end else if (uf_op == 2'b01) begin
      ra = root_of(uf_node1);
      rb = root_of(uf_node2);
      if (ra < rb) parent[rb] = ra;
      else if (rb < ra) parent[ra] = rb;
      res_q  <= (ra < rb) ? ra : rb;
      op_cnt <= 2 + int'(uf_node1[0]);
    end else if (uf_op == 2'b10) begin
      res_q  <= root_of(uf_node1);
      op_cnt <= 2 + int'(uf_node1[0]);
    end
  end

  // Observation on the falling edge.
  pair_t union_q [$];
  pair_t remap_q [$];
  int    resolve_cnt = 0;
  int    ufs_cnt = 0;
  int    proto_err = 0;

  always @(negedge clk) begin
    if (uf_op == 2'b01) union_q.push_back('{uf_node1, uf_node2});
    if (uf_op != 2'b00 && (!uf_idle || uf_frame_start)) proto_err++;
    if (uf_op == 2'b11) proto_err++;
    if (remap_valid) remap_q.push_back('{remap_addr, remap_data});
    if (resolve_done) resolve_cnt++;
    if (uf_frame_start) ufs_cnt++;
  end

  int            checks = 0;
  int            errors = 0;
  int            last_stalls = 0;
  pair_vec_t     vecs [$];
  logic [AW-1:0] exp_root [0:N-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [AW-1:0] a, input logic [AW-1:0] b, input bit stored);
    vecs.push_back('{a, b, stored});
  endtask

  task automatic set_identity_roots();
    for (int i = 0; i < N; i++) exp_root[i] = AW'(i);
  endtask

  // From idle: uf_frame_start must be a single pulse at +1, eq_ready must first rise at +N+3.
  task automatic start_frame(input string name);
    int ufs_hi, ufs_at, ready_at;
    ufs_hi = 0; ufs_at = -1; ready_at = -1;
    @(negedge clk);
    frame_start = 1'b1;
    for (int t = 1; t < 200; t++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (uf_frame_start) begin
        ufs_hi++;
        ufs_at = t;
      end
      if (eq_ready) begin
        ready_at = t;
        break;
      end
    end
    check({name, "_uf_frame_start_width"}, ufs_hi, 1);
    check({name, "_uf_frame_start_cycle"}, ufs_at, 1);
    check({name, "_eq_ready_rise_cycle"}, ready_at, N + 3);
  endtask

  task automatic send_pair(input logic [AW-1:0] a, input logic [AW-1:0] b, output int stalls);
    eq_a = a;
    eq_b = b;
    eq_valid = 1'b1;
    stalls = 0;
    while (!eq_ready && stalls < 200) begin
      @(negedge clk);
      stalls++;
    end
    check("handshake_ready", eq_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic end_frame(input logic [AW-1:0] m);
    @(negedge clk);
    frame_end = 1'b1;
    max_label = m;
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  task automatic run_frame(input logic [AW-1:0] maxl, input int exp_comps, input string name);
    int stalls, base_res, k;
    union_q.delete();
    remap_q.delete();
    base_res = resolve_cnt;
    last_stalls = 0;
    foreach (vecs[i]) begin
      send_pair(vecs[i].a, vecs[i].b, stalls);
      last_stalls += stalls;
    end
    eq_valid = 1'b0;
    end_frame(maxl);
    for (int n = 0; n < 3000 && resolve_cnt == base_res; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({name, "_resolve_pulses"}, resolve_cnt - base_res, 1);
    k = 0;
    foreach (vecs[i]) begin
      if (vecs[i].stored) begin
        if (k < union_q.size()) begin
          check({name, "_union_node1"}, union_q[k].a, vecs[i].a);
          check({name, "_union_node2"}, union_q[k].b, vecs[i].b);
        end
        k++;
      end
    end
    check({name, "_union_count"}, union_q.size(), k);
    check({name, "_remap_count"}, remap_q.size(), int'(maxl));
    for (int j = 0; j < remap_q.size() && j + 1 < N; j++) begin
      check({name, "_remap_addr"}, remap_q[j].a, AW'(j + 1));
      check({name, "_remap_data"}, remap_q[j].b, exp_root[j + 1]);
    end
    check({name, "_num_components"}, num_components, exp_comps);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    int st, nf, base_res, base_ufs, lat;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_uf_op", uf_op, 2'b00);
    check("rst_uf_frame_start", uf_frame_start, 1'b0);
    check("rst_eq_ready", eq_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_remap_valid", remap_valid, 1'b0);
    check("rst_resolve_done", resolve_done, 1'b0);
    check("rst_num_components", num_components, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // A: chain 1-2, 3-4, 2-3 joins labels 1..4 under root 1; label 5 stays alone.
    start_frame("a");
    vecs.delete();
    add_vec(1, 2, 1'b1);
    add_vec(3, 4, 1'b1);
    add_vec(2, 3, 1'b1);
    set_identity_roots();
    exp_root[2] = 1; exp_root[3] = 1; exp_root[4] = 1;
    run_frame(5, 2, "a");

    // B: background and self pairs are accepted but never reach union_find.
    start_frame("b");
    vecs.delete();
    add_vec(0, 7, 1'b0);
    add_vec(6, 6, 1'b0);
    set_identity_roots();
    run_frame(7, 7, "b");

    // C: six back-to-back pairs overflow the four-entry buffer.
    start_frame("c");
    vecs.delete();
    for (int i = 0; i < 6; i++) add_vec(AW'(2 * i + 1), AW'(2 * i + 2), 1'b1);
    set_identity_roots();
    for (int l = 2; l <= 12; l += 2) exp_root[l] = AW'(l - 1);
    run_frame(12, 6, "c");
    check("c_ready_backpressure", last_stalls > 0, 1'b1);

    // E: frame_start while a find is outstanding aborts the frame.
    start_frame("e");
    remap_q.delete();
    send_pair(1, 2, st);
    eq_valid = 1'b0;
    end_frame(5);
    nf = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (uf_op == 2'b10) begin
        nf++;
        if (nf == 2) break;
      end
    end
    check("e_second_find_seen", nf, 2);
    base_res = resolve_cnt;
    base_ufs = ufs_cnt;
    @(negedge clk);
    frame_start = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (eq_ready) break;
    end
    check("e_restart_ready", eq_ready, 1'b1);
    check("e_restart_init_pulse", ufs_cnt - base_ufs, 1);
    check("e_no_resolve_done", resolve_cnt - base_res, 0);
    check("e_remap_writes", remap_q.size(), 1);
    if (remap_q.size() > 0) check("e_remap_first_data", remap_q[0].b, 1);
    check("e_num_components_held", num_components, 6);

    // R: the restarted frame resolves normally.
    vecs.delete();
    add_vec(2, 1, 1'b1);
    set_identity_roots();
    exp_root[2] = 1;
    run_frame(2, 1, "r");

    // D: max_label=0 resolves with no finds, two cycles after frame_end.
    start_frame("d");
    remap_q.delete();
    frame_end = 1'b1;
    max_label = 0;
    lat = -1;
    for (int t = 1; t < 50; t++) begin
      @(negedge clk);
      frame_end = 1'b0;
      if (resolve_done) begin
        lat = t;
        break;
      end
    end
    check("d_resolve_latency", lat, 2);
    check("d_num_components", num_components, 0);
    @(negedge clk);
    check("d_resolve_one_cycle", resolve_done, 1'b0);
    check("d_busy_after", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("d_no_remap", remap_q.size(), 0);

    // F: reset in the middle of a frame.
    start_frame("f");
    send_pair(5, 6, st);
    eq_valid = 1'b0;
    @(negedge clk);
    check("f_busy_before_reset", busy, 1'b1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("f_rst_uf_op", uf_op, 2'b00);
    check("f_rst_busy", busy, 1'b0);
    check("f_rst_eq_ready", eq_ready, 1'b0);
    check("f_rst_remap_valid", remap_valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    check("protocol_violations", proto_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
